// File: rtl/burst_rd_master_pkg.sv
// Shared definitions for the burst read master: FSM state encoding,
// the zero-word length constant and address helpers.
package burst_rd_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [15:0] ZERO_WORDS = 16'd0;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    // Clear the byte-offset bits so the address points at a whole word.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO holding read data for the burst read master.
// DP must be a power of two so the pointers wrap naturally.
// Push and pop in the same cycle are accepted even when full.
module sync_fifo #(
    parameter int DP = 4,
    parameter int DW = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [DW-1:0]          din_i,
    input  logic                   pop_i,
    output logic [DW-1:0]          dout_o,
    output logic                   valid_o,
    output logic [$clog2(DP):0]    count_o
);

    localparam int AW = $clog2(DP);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DP);

    logic [DW-1:0] mem_q [DP];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          rd_en_s;
    logic          wr_en_s;

    assign rd_en_s = pop_i && (cnt_q != {CW{1'b0}});
    assign wr_en_s = push_i && ((cnt_q != FULL_C) || rd_en_s);

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DP; i++) begin
                mem_q[i] <= {DW{1'b0}};
            end
            wr_q  <= {AW{1'b0}};
            rd_q  <= {AW{1'b0}};
            cnt_q <= {CW{1'b0}};
        end else begin
            if (wr_en_s) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (rd_en_s) begin
                rd_q <= rd_q + AW'(1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_q];
    assign valid_o = (cnt_q != {CW{1'b0}});
    assign count_o = cnt_q;

endmodule

// File: rtl/burst_rd_master.sv
// Burst read master: issues len_i word reads starting at base_addr_i,
// buffers responses in a credit-limited FIFO and streams them out.
// Optional macro BURST_RD_ALIGN_CHK_EN rejects word-misaligned starts
// with an err_o pulse; without it the low address bits are dropped.
module burst_rd_master
    import burst_rd_master_pkg::*;
#(
    parameter int FIFO_DP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [31:0] base_addr_i,
    input  logic [15:0] len_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    output logic [3:0]  sel_o,
    output logic        we_o,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    input  logic        rsp_valid_i,
    output logic        rsp_ready_o,
    input  logic [31:0] data_i,
    output logic [31:0] dout_o,
    output logic        dout_valid_o,
    input  logic        dout_ready_i
);

    localparam int CW  = $clog2(FIFO_DP) + 1;
    localparam int CW1 = CW + 1;
    localparam logic [CW:0] DP_LIM = CW1'(FIFO_DP);

    state_e        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [15:0]   req_rem_q, req_rem_d;
    logic [15:0]   pop_rem_q, pop_rem_d;
    logic [CW-1:0] outst_q, outst_d;
    logic          req_valid_q, req_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [CW-1:0] fifo_cnt_s;
    logic          fifo_valid_s;
    logic [31:0]   fifo_dout_s;
    logic          acc_s;
    logic          pop_s;
    logic          push_s;
    logic          last_pop_s;
    logic          misalign_s;
    logic [CW:0]   sum_next_s;

`ifdef BURST_RD_ALIGN_CHK_EN
    assign misalign_s = (base_addr_i[1:0] != 2'b00);
`else
    assign misalign_s = 1'b0;
`endif

    assign acc_s      = req_valid_q && req_ready_i;
    assign pop_s      = fifo_valid_s && dout_ready_i;
    // Responses only count while a burst is live; stragglers after reset are dropped.
    assign push_s     = rsp_valid_i && (state_q != ST_IDLE);
    assign last_pop_s = pop_s && (pop_rem_q == 16'd1);
    // A push cancels its own outstanding-read decrement, so it does not move the credit sum.
    assign sum_next_s = {1'b0, fifo_cnt_s} + {1'b0, outst_q} + {{CW{1'b0}}, acc_s}
                        - {{CW{1'b0}}, pop_s};

    sync_fifo #(
        .DP (FIFO_DP),
        .DW (32)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .din_i   (data_i),
        .pop_i   (pop_s),
        .dout_o  (fifo_dout_s),
        .valid_o (fifo_valid_s),
        .count_o (fifo_cnt_s)
    );

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        req_rem_d = req_rem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        pop_rem_d = pop_s ? (pop_rem_q - 16'd1) : pop_rem_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (misalign_s) begin
                        err_d = 1'b1;
                    end else if (len_i == ZERO_WORDS) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = ST_ISSUE;
                        busy_d    = 1'b1;
                        addr_d    = align_word(base_addr_i);
                        req_rem_d = len_i;
                        pop_rem_d = len_i;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (acc_s) begin
                    addr_d    = addr_q + WORD_BYTES;
                    req_rem_d = req_rem_q - 16'd1;
                    state_d   = (req_rem_q == 16'd1) ? ST_DRAIN : ST_ISSUE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (last_pop_s) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        case ({acc_s, push_s})
            2'b10:   outst_d = outst_q + CW'(1);
            2'b01:   outst_d = outst_q - CW'(1);
            default: outst_d = outst_q;
        endcase

        req_valid_d = (state_d == ST_ISSUE) && (req_rem_d != ZERO_WORDS) &&
                      (sum_next_s < DP_LIM);
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= 32'd0;
            req_rem_q   <= ZERO_WORDS;
            pop_rem_q   <= ZERO_WORDS;
            outst_q     <= {CW{1'b0}};
            req_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            req_rem_q   <= req_rem_d;
            pop_rem_q   <= pop_rem_d;
            outst_q     <= outst_d;
            req_valid_q <= req_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign addr_o       = addr_q;
    assign data_o       = 32'd0;
    assign sel_o        = 4'hf;
    assign we_o         = 1'b0;
    assign req_valid_o  = req_valid_q;
    assign rsp_ready_o  = 1'b1;
    assign dout_o       = fifo_dout_s;
    assign dout_valid_o = fifo_valid_s;

endmodule

// File: tb/tb_burst_rd_master.sv
// Scoreboard bench for burst_rd_master: directed bursts push expected
// addresses and data into queues; a negedge monitor pops and compares.
module tb_burst_rd_master;

    localparam logic [31:0] KEY = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] base_addr_i = 32'd0;
    logic [15:0] len_i = 16'd0;
    logic        busy_o, done_o, err_o;
    logic [31:0] addr_o, data_o;
    logic [3:0]  sel_o;
    logic        we_o, req_valid_o;
    logic        req_ready_i = 1'b1;
    logic        rsp_valid_i = 1'b0;
    logic        rsp_ready_o;
    logic [31:0] data_i = 32'd0;
    logic [31:0] dout_o;
    logic        dout_valid_o;
    logic        dout_ready_i = 1'b1;
    logic        stray = 1'b0;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int pop_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] pend_q[$];

    always #5 clk = ~clk;

    burst_rd_master #(.FIFO_DP(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
        .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .addr_o(addr_o), .data_o(data_o), .sel_o(sel_o), .we_o(we_o),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o), .data_i(data_i),
        .dout_o(dout_o), .dout_valid_o(dout_valid_o), .dout_ready_i(dout_ready_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One-cycle responder: data for an accepted address comes back next cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_q.delete();
            rsp_valid_i = 1'b0;
            data_i      = 32'd0;
        end else begin
            if (pend_q.size() > 0) begin
                rsp_valid_i = 1'b1;
                data_i      = pend_q.pop_front() ^ KEY;
            end else if (stray) begin
                rsp_valid_i = 1'b1;
                data_i      = 32'hDEAD_BEEF;
            end else begin
                rsp_valid_i = 1'b0;
                data_i      = 32'd0;
            end
            if (req_valid_o && req_ready_i) pend_q.push_back(addr_o);
        end
    end

    // Monitor: compare every transferred request and stream word against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_valid_o && req_ready_i) begin
                acc_cnt++;
                if (exp_addr_q.size() == 0) check("req_unexpected", addr_o, 32'hxxxx_xxxx);
                else check("req_addr", addr_o, exp_addr_q.pop_front());
            end
            if (dout_valid_o && dout_ready_i) begin
                pop_cnt++;
                if (exp_data_q.size() == 0) check("dout_unexpected", dout_o, 32'hxxxx_xxxx);
                else check("dout_data", dout_o, exp_data_q.pop_front());
            end
            if (done_o) done_cnt++;
            if (err_o) err_cnt++;
        end
    end

    task automatic push_exp(input logic [31:0] base, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + 32'(4 * i);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(a ^ KEY);
        end
    endtask

    task automatic start_burst(input logic [31:0] base, input logic [15:0] len);
        start_i = 1'b1;
        base_addr_i = base;
        len_i = len;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max, output int cyc);
        cyc = 0;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk); #1;
            if (done_o) begin
                cyc = i;
                break;
            end
        end
        check({name, "_done_seen"}, 32'(cyc != 0), 32'd1);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_req_valid"}, 32'(req_valid_o), 32'd0);
        check({name, "_dout_valid"}, 32'(dout_valid_o), 32'd0);
        check({name, "_busy"}, 32'(busy_o), 32'd0);
        check({name, "_done"}, 32'(done_o), 32'd0);
        check({name, "_err"}, 32'(err_o), 32'd0);
        check({name, "_addr"}, addr_o, 32'd0);
    endtask

    initial begin
        int cyc, a0, p0, d0, e0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("rst");
        check("rst_sel", 32'(sel_o), 32'h0000_000f);
        check("rst_we_data", 32'(we_o) | data_o, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rsp_ready", 32'(rsp_ready_o), 32'd1);

        // Basic burst, plus a start while busy that must be ignored.
        push_exp(32'h0000_0100, 4);
        d0 = done_cnt; p0 = pop_cnt;
        start_burst(32'h0000_0100, 16'd4);
        check("t2_busy", 32'(busy_o), 32'd1);
        start_i = 1'b1; len_i = 16'd0;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_done("t2", 50, cyc);
        @(posedge clk); #1;
        check("t2_done_once", 32'(done_cnt - d0), 32'd1);
        check("t2_pops", 32'(pop_cnt - p0), 32'd4);
        check("t2_busy_after", 32'(busy_o), 32'd0);
        check("t2_left", 32'(exp_data_q.size()), 32'd0);

        // Stream stalled: only FIFO_DP requests may be issued.
        dout_ready_i = 1'b0;
        push_exp(32'h0000_0400, 8);
        a0 = acc_cnt; p0 = pop_cnt;
        start_burst(32'h0000_0400, 16'd8);
        repeat (20) begin @(posedge clk); #1; end
        check("t3_credit_reqs", 32'(acc_cnt - a0), 32'd4);
        check("t3_req_valid", 32'(req_valid_o), 32'd0);
        check("t3_dout_valid", 32'(dout_valid_o), 32'd1);
        dout_ready_i = 1'b1;
        wait_done("t3", 100, cyc);
        check("t3_pops", 32'(pop_cnt - p0), 32'd8);
        check("t3_left", 32'(exp_addr_q.size() + exp_data_q.size()), 32'd0);

        // Address wrap, with the request held under req_ready_i low.
        req_ready_i = 1'b0;
        push_exp(32'hFFFF_FFF8, 3);
        start_burst(32'hFFFF_FFF8, 16'd3);
        for (int i = 0; i < 3; i++) begin
            check("t4_hold_valid", 32'(req_valid_o), 32'd1);
            check("t4_hold_addr", addr_o, 32'hFFFF_FFF8);
            @(posedge clk); #1;
        end
        req_ready_i = 1'b1;
        wait_done("t4", 50, cyc);
        check("t4_left", 32'(exp_addr_q.size() + exp_data_q.size()), 32'd0);

        // Zero-length start.
        a0 = acc_cnt;
        start_burst(32'h0000_0500, 16'd0);
        check("t5_done", 32'(done_o), 32'd1);
        check("t5_busy", 32'(busy_o), 32'd0);
        @(posedge clk); #1;
        check("t5_done_clear", 32'(done_o), 32'd0);
        check("t5_no_req", 32'(acc_cnt - a0), 32'd0);

        // Misaligned start.
        a0 = acc_cnt; e0 = err_cnt;
`ifdef BURST_RD_ALIGN_CHK_EN
        start_burst(32'h0000_0102, 16'd2);
        check("t6_err", 32'(err_o), 32'd1);
        check("t6_busy", 32'(busy_o), 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        check("t6_no_req", 32'(acc_cnt - a0), 32'd0);
        check("t6_err_once", 32'(err_cnt - e0), 32'd1);
`else
        push_exp(32'h0000_0100, 2);
        start_burst(32'h0000_0102, 16'd2);
        wait_done("t6", 50, cyc);
        check("t6_reqs", 32'(acc_cnt - a0), 32'd2);
        check("t6_no_err", 32'(err_cnt - e0), 32'd0);
`endif

        // Back-to-back throughput: len words finish len+2 cycles after start.
        push_exp(32'h0000_0600, 8);
        start_burst(32'h0000_0600, 16'd8);
        wait_done("t7", 50, cyc);
        check("t7_cycles", 32'(cyc), 32'd10);

        // Reset during the third word, then a clean burst.
        push_exp(32'h0000_0300, 6);
        p0 = pop_cnt; cyc = 0;
        start_burst(32'h0000_0300, 16'd6);
        for (int i = 0; i < 50; i++) begin
            if (pop_cnt - p0 >= 2) begin cyc = 1; break; end
            @(posedge clk); #1;
        end
        check("t8_reach_word3", 32'(cyc), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t8_rst");
        exp_addr_q.delete();
        exp_data_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        stray = 1'b1;
        @(posedge clk); #1;
        stray = 1'b0;
        check("t8_stray_dropped", 32'(dout_valid_o), 32'd0);
        push_exp(32'h0000_0200, 2);
        p0 = pop_cnt;
        start_burst(32'h0000_0200, 16'd2);
        wait_done("t8", 50, cyc);
        check("t8_pops", 32'(pop_cnt - p0), 32'd2);
        check("t8_left", 32'(exp_addr_q.size() + exp_data_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
